// File: rtl/decode_n_seq.sv
// Registered N-to-2^N one-hot decoder with a valid/ready command port.
// Supports three drive modes: single-cycle pulse, timed hold, and a full scan across every output.
module decode_n_seq #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         de_in,
    input  logic                 data,
    input  logic [1:0]           mode,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 abort,
    output logic [(1<<N)-1:0]    de_out,
    output logic                 out_valid,
    output logic [N-1:0]         scan_idx,
    output logic                 done
);

    localparam int            OUT_W     = 1 << N;
    localparam logic [OUT_W-1:0] ONE_HOT0 = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [N:0]    LAST_STEP = {1'b0, {N{1'b1}}};

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        idx_q, idx_d;
    logic [DWELL_W-1:0]  dcnt_q, dcnt_d;
    logic [N:0]          step_q, step_d;
    logic [OUT_W-1:0]    de_out_q, de_out_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;

    // Captured command fields; only meaningful while ACTIVE, so they carry no reset.
    logic                data_q, data_d;
    logic                scan_q, scan_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;

    logic accept;

    assign in_ready = rst_n & ~abort & ((state_q == IDLE) | done_q);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dcnt_d      = dcnt_q;
        step_d      = step_q;
        data_d      = data_q;
        scan_d      = scan_q;
        dwell_d     = dwell_q;

        if (accept) begin
            state_d = ACTIVE;
            idx_d   = de_in;
            data_d  = data;
            scan_d  = (mode == 2'b10);
            // Pulse (and reserved) behaves as a hold of length one.
            dwell_d = ((mode == 2'b01) || (mode == 2'b10)) ? dwell : '0;
            dcnt_d  = '0;
            step_d  = '0;
        end else if (state_q == ACTIVE) begin
            if (abort || done_q) begin
                state_d = IDLE;
            end else if (dcnt_q == dwell_q) begin
                dcnt_d = '0;
                step_d = step_q + 1'b1;
                idx_d  = idx_q + 1'b1;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        out_valid_d = (state_d == ACTIVE);
        done_d      = out_valid_d && (dcnt_d == dwell_d) && (!scan_d || (step_d == LAST_STEP));
        de_out_d    = (out_valid_d && data_d) ? (ONE_HOT0 << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dcnt_q      <= '0;
            step_q      <= '0;
            de_out_q    <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dcnt_q      <= dcnt_d;
            step_q      <= step_d;
            de_out_q    <= de_out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q  <= data_d;
        scan_q  <= scan_d;
        dwell_q <= dwell_d;
    end

    assign de_out    = de_out_q;
    assign out_valid = out_valid_q;
    assign scan_idx  = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_decode_n_seq.sv
// Directed bench for decode_n_seq (N=3, DWELL_W=4): reset, pulse, hold, scan, abort,
// back-to-back and mid-operation reset.
module tb_decode_n_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] de_in;
    logic       data;
    logic [1:0] mode;
    logic [3:0] dwell;
    logic       abort;
    logic [7:0] de_out;
    logic       out_valid;
    logic [2:0] scan_idx;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    decode_n_seq #(.N(3), .DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .de_in(de_in), .data(data), .mode(mode), .dwell(dwell), .abort(abort),
        .de_out(de_out), .out_valid(out_valid), .scan_idx(scan_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; de_in = '0; data = 1'b0;
        mode = 2'b00; dwell = '0; abort = 1'b0;
        tick(); tick();
        n_checks++; if (de_out !== 8'h00) begin n_fail++; $display("FAIL reset_de_out got %h exp 00", de_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (scan_idx !== 3'd0) begin n_fail++; $display("FAIL reset_scan_idx got %0d exp 0", scan_idx); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got %b exp 0", in_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_release got %b exp 1", in_ready); end
    endtask

    task automatic test_pulse();
        logic [7:0] exp;
        mode = 2'b00; data = 1'b1; dwell = 4'd9; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            de_in = 3'(i);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pulse_in_ready i=%0d got %b exp 1", i, in_ready); end
            tick();
            exp = 8'h01 << i;
            n_checks++; if (de_out !== exp) begin n_fail++; $display("FAIL pulse_de_out i=%0d got %h exp %h", i, de_out, exp); end
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pulse_done i=%0d got %b exp 1", i, done); end
            n_checks++; if (scan_idx !== 3'(i)) begin n_fail++; $display("FAIL pulse_scan_idx i=%0d got %0d exp %0d", i, scan_idx, i); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || de_out !== 8'h00) begin n_fail++; $display("FAIL pulse_idle got vld=%b out=%h exp 0/00", out_valid, de_out); end
    endtask

    task automatic test_hold();
        mode = 2'b01; de_in = 3'd5; dwell = 4'd3; data = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; de_in = 3'd0; dwell = 4'd0; mode = 2'b10;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_checks++; if (de_out !== 8'h20) begin n_fail++; $display("FAIL hold_de_out c=%0d got %h exp 20", c, de_out); end
            n_checks++; if (done !== (c == 4)) begin n_fail++; $display("FAIL hold_done c=%0d got %b exp %b", c, done, (c == 4)); end
            n_checks++; if (in_ready !== (c == 4)) begin n_fail++; $display("FAIL hold_in_ready c=%0d got %b exp %b", c, in_ready, (c == 4)); end
            tick();
        end
        n_checks++; if (de_out !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_end got out=%h vld=%b exp 00/0", de_out, out_valid); end
    endtask

    task automatic test_scan();
        logic [2:0] eidx;
        mode = 2'b10; de_in = 3'd6; dwell = 4'd1; data = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            eidx = 3'((6 + c / 2) % 8);
            n_checks++; if (scan_idx !== eidx) begin n_fail++; $display("FAIL scan_idx c=%0d got %0d exp %0d", c, scan_idx, eidx); end
            n_checks++; if (de_out !== (8'h01 << eidx)) begin n_fail++; $display("FAIL scan_de_out c=%0d got %h exp %h", c, de_out, 8'h01 << eidx); end
            n_checks++; if (done !== (c == 15)) begin n_fail++; $display("FAIL scan_done c=%0d got %b exp %b", c, done, (c == 15)); end
            tick();
        end
        n_checks++; if (out_valid !== 1'b0 || de_out !== 8'h00) begin n_fail++; $display("FAIL scan_end got vld=%b out=%h exp 0/00", out_valid, de_out); end
        n_checks++; if (scan_idx !== 3'd5) begin n_fail++; $display("FAIL scan_idx_hold got %0d exp 5", scan_idx); end
    endtask

    task automatic test_abort();
        mode = 2'b10; de_in = 3'd0; dwell = 4'd2; data = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (out_valid !== 1'b1 || de_out !== 8'h02) begin n_fail++; $display("FAIL abort_pre got vld=%b out=%h exp 1/02", out_valid, de_out); end
        abort = 1'b1; in_valid = 1'b1; mode = 2'b00; de_in = 3'd7;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready got %b exp 0", in_ready); end
        tick();
        abort = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || de_out !== 8'h00) begin n_fail++; $display("FAIL abort_next got vld=%b out=%h exp 0/00", out_valid, de_out); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b exp 0", done); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_not_accepted got vld=%b done=%b exp 0/0", out_valid, done); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e1, e2;
        for (int r = 0; r < 2; r++) begin
            data = (r == 0);
            e1 = (r == 0) ? 8'h04 : 8'h00;
            e2 = (r == 0) ? 8'h08 : 8'h00;
            mode = 2'b01; de_in = 3'd2; dwell = 4'd0; in_valid = 1'b1;
            tick();
            n_checks++; if (de_out !== e1 || done !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first r=%0d got out=%h done=%b vld=%b exp %h/1/1", r, de_out, done, out_valid, e1); end
            mode = 2'b00; de_in = 3'd3;
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready r=%0d got %b exp 1", r, in_ready); end
            tick();
            in_valid = 1'b0;
            n_checks++; if (de_out !== e2 || done !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second r=%0d got out=%h done=%b vld=%b exp %h/1/1", r, de_out, done, out_valid, e2); end
            n_checks++; if (scan_idx !== 3'd3) begin n_fail++; $display("FAIL b2b_scan_idx r=%0d got %0d exp 3", r, scan_idx); end
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle r=%0d got %b exp 0", r, out_valid); end
        end
    endtask

    task automatic test_reset_mid_hold();
        mode = 2'b01; de_in = 3'd1; dwell = 4'd15; data = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        n_checks++; if (de_out !== 8'h02 || out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got out=%h vld=%b exp 02/1", de_out, out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
        tick();
        n_checks++; if (de_out !== 8'h00 || out_valid !== 1'b0 || done !== 1'b0 || scan_idx !== 3'd0) begin n_fail++; $display("FAIL midrst_outputs got out=%h vld=%b done=%b idx=%0d exp 00/0/0/0", de_out, out_valid, done, scan_idx); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after got %b exp 1", in_ready); end
        mode = 2'b00; de_in = 3'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (de_out !== 8'h10 || done !== 1'b1) begin n_fail++; $display("FAIL midrst_pulse got out=%h done=%b exp 10/1", de_out, done); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_pulse_end got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_hold();
        test_scan();
        test_abort();
        test_back_to_back();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_n_seq.md
# decode_n_seq

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready command interface and three drive modes: single-cycle pulse, timed hold, and auto-scan across all outputs. It is the sequential successor to the combinational 3-to-8 decoder. It sits between a command source (bus register or controller FSM) and one-hot select/strobe lines such as chip selects, mux selects or test-pattern lanes.

## Interface
- N, 3, select width; outputs = 1<<N (N = 1..8)
- DWELL_W, 4, width of dwell count; each driven step lasts dwell+1 cycles
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  command present
- in_ready  out  1  block can accept command this cycle
- de_in  in  N  start/target output index
- data  in  1  value driven on the selected line (0 = selected line stays low, sequencing still runs)
- mode  in  2  00 pulse, 01 hold, 10 scan, 11 reserved (= pulse)
- dwell  in  DWELL_W  per-step length minus one (hold/scan only)
- abort  in  1  cancel current operation
- de_out  out  1<<N  registered decoded output; at most one bit set
- out_valid  out  1  an operation is active this cycle
- scan_idx  out  N  index currently driven
- done  out  1  one-cycle pulse on the last active cycle of an operation

## Operation
- States: IDLE, ACTIVE. Accept = in_valid & in_ready.
- On accept, capture de_in, data, mode, dwell; later changes are ignored until the next accept.
- in_ready = rst_n & ~abort & (IDLE | done). Back-to-back commands are accepted in the last active cycle.
- Pulse: de_out[de_in] = data for 1 cycle; done in that cycle; dwell ignored.
- Hold: de_out[de_in] = data for dwell+1 cycles; done in the last one.
- Scan: start at de_in. Drive each index for dwell+1 cycles, then advance by one. Index wraps from (1<<N)-1 to 0.
  - Stop after 1<<N steps, i.e. every output exactly once; done in the final cycle of the last step.
- Dwell counter is DWELL_W bits, counts 0..dwell. Step counter is N+1 bits, counts 0..(1<<N)-1.
- In ACTIVE: out_valid = 1 and scan_idx = driven index. In IDLE: de_out = 0, out_valid = 0, scan_idx holds its last value.
- abort = 1 in ACTIVE: next cycle is IDLE with de_out = 0; no done pulse. abort in IDLE has no effect. abort always blocks accept that cycle.
- Accept in the done cycle: the next cycle starts the new operation directly, with no gap cycle.
- de_out never has more than one bit set. It is all-zero whenever data = 0 or state = IDLE.

## Timing
- Reset (rst_n low at an edge) forces, from the next cycle: state IDLE, de_out = 0, out_valid = 0, done = 0, scan_idx = 0, counters = 0.
- in_ready = 0 while rst_n is low. Reset mid-operation drops the operation silently.
- Latency: a command accepted at edge k drives de_out from edge k+1.
- Pulse: active in cycle k+1 only.
- Hold: active cycles k+1 .. k+1+dwell.
- Scan: active cycles k+1 .. k+(1<<N)*(dwell+1).
- Pulse-mode throughput is 1 command per cycle when in_valid stays high.
- All outputs except in_ready are registered; in_ready is combinational from state/done/abort/rst_n.

## Test plan
- Reset, then pulse mode: for de_in = 0..7 with data = 1 and in_valid held high → de_out = 0x01, 0x02 … 0x80 on consecutive cycles; done = 1 and in_ready = 1 every cycle.
- Hold: de_in = 5, dwell = 3, data = 1 → de_out = 0x20 for exactly 4 cycles, done on the 4th, then 0x00; in_ready low in cycles 1-3.
- Scan: de_in = 6, dwell = 1, N = 3 → indices 6,7,0,1,2,3,4,5, each for 2 cycles (16 cycles total); done in cycle 16; scan_idx tracks each index.
- Abort: start scan with dwell = 2, assert abort in cycle 4 together with in_valid → de_out = 0 and out_valid = 0 next cycle, no done pulse, command not accepted.
- Back-to-back: hold(de_in = 2, dwell = 0), then pulse(de_in = 3) offered during the done cycle → 0x04 then 0x08 on adjacent cycles. Repeat with data = 0 → de_out stays 0 while out_valid and done still sequence.
- Reset mid-hold (dwell = 15, rst_n low in cycle 5) → all outputs 0 the next cycle; after release, in_ready = 1 and a new pulse works.
